// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and types for the arb_mux slice.
//   WIDTH_DEF      default data width of channels x, y and out
//   SRC_Y / SRC_X  source codes driven on sel (also grant vector bit indices)
//   state_t        output-stage FSM states
package arb_mux_pkg;

    localparam int unsigned WIDTH_DEF = 10;

    localparam int unsigned SRC_Y = 0;
    localparam int unsigned SRC_X = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/arb_mux_if.sv
// arb_mux_if: handshake bundle for arb_mux.
//   x, x_valid, x_ready      channel x (source code 1)
//   y, y_valid, y_ready      channel y (source code 0)
//   out, out_valid, out_ready, sel   merged output and its source
// Modports: master = traffic source/sink around the mux, slave = arb_mux itself.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic             x_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             sel;

    modport master (
        output x, x_valid, y, y_valid, out_ready,
        input  x_ready, y_ready, out, out_valid, sel
    );

    modport slave (
        input  x, x_valid, y, y_valid, out_ready,
        output x_ready, y_ready, out, out_valid, sel
    );

endinterface

// File: rtl/arb_mux_rr_arbiter2.sv
// rr_arbiter2: two-requester arbiter producing a one-hot grant.
//   req[1:0]   requests, indexed by source code (bit 1 = x, bit 0 = y)
//   en         grant allowed this cycle (output stage loadable, not in reset)
//   grant[1:0] one-hot grant, all zero when en is low or nobody requests
// Build option ARB_MUX_RR_EN:
//   defined   round-robin; a last-grant register picks the channel not
//             granted last on contention; clk/rst ports exist only here
//   undefined fixed priority, x wins contention; no state, no clock
module rr_arbiter2
    import arb_mux_pkg::*;
(
`ifdef ARB_MUX_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef ARB_MUX_RR_EN
    // 1 = x was granted last; reset to y so the first contention goes to x
    logic last_x;

    // any grant is a completed transfer, since ready == grant and the
    // grant only goes to a valid requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_x <= 1'b0;
        end else if (|grant) begin
            last_x <= grant[SRC_X];
        end
    end

    always_comb begin
        grant = '0;
        if (en) begin
            if (req[SRC_X] && req[SRC_Y]) begin
                if (last_x) begin
                    grant[SRC_Y] = 1'b1;
                end else begin
                    grant[SRC_X] = 1'b1;
                end
            end else begin
                grant = req;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        if (en) begin
            if (req[SRC_X]) begin
                grant[SRC_X] = 1'b1;
            end else if (req[SRC_Y]) begin
                grant[SRC_Y] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/arb_mux.sv
// arb_mux: arbitrated 2:1 merge of valid/ready channels x and y into a
// one-entry registered output stage.
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   arb_mux_if.slave: x/y inputs with valid/ready, out/out_valid/
//         out_ready output handshake, sel = source of out (1 = x, 0 = y)
// Build option ARB_MUX_RR_EN selects round-robin arbitration (defined) or
// fixed x-priority (undefined); see rr_arbiter2.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
)(
    input  logic       clk,
    input  logic       rst,
    arb_mux_if.slave   bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_q, out_nxt;
    logic             sel_q, sel_nxt;

    logic [1:0]       req;
    logic [1:0]       grant;
    logic             loadable;
    logic             en;

    assign req[SRC_X] = bus.x_valid;
    assign req[SRC_Y] = bus.y_valid;

    // drain and reload in the same cycle when the consumer takes the word;
    // gating with rst keeps every ready low while reset is held
    assign loadable = (state == EMPTY) || bus.out_ready;
    assign en       = loadable && rst;

    rr_arbiter2 u_arb (
`ifdef ARB_MUX_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .req   (req),
        .en    (en),
        .grant (grant)
    );

    assign bus.x_ready   = grant[SRC_X];
    assign bus.y_ready   = grant[SRC_Y];
    assign bus.out       = out_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            out_q <= out_nxt;
            sel_q <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        sel_nxt   = sel_q;
        if (|grant) begin
            state_nxt = FULL;
            out_nxt   = grant[SRC_X] ? bus.x : bus.y;
            sel_nxt   = grant[SRC_X];
        end else if (state == FULL && bus.out_ready) begin
            // drained with nothing to load: out and sel keep the last word
            state_nxt = EMPTY;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

    localparam int unsigned W = 10;

    logic clk;
    logic rst;

    arb_mux_if #(.WIDTH(W)) bus ();

    arb_mux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // reference model: the word held downstream, its source, and who won last
    bit          m_valid;
    logic [W-1:0] m_out;
    bit          m_sel;
    bit          m_lastx;

    function automatic void model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_sel   = 1'b0;
        m_lastx = 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven. Predicts readies from
    // the handshake rules, checks everything at the falling edge, then
    // advances the model across the next rising edge.
    task automatic tick();
        bit ld, gx, gy;
        ld = rst && (!m_valid || bus.out_ready);
        if (bus.x_valid && bus.y_valid) begin
`ifdef ARB_MUX_RR_EN
            gx = !m_lastx;
`else
            gx = 1'b1;
`endif
            gy = !gx;
        end else begin
            gx = bus.x_valid;
            gy = bus.y_valid;
        end
        gx = gx && ld;
        gy = gy && ld;
        #4;
        check("x_ready",   {31'b0, bus.x_ready},   {31'b0, gx});
        check("y_ready",   {31'b0, bus.y_ready},   {31'b0, gy});
        check("out",       {22'b0, bus.out},       {22'b0, m_out});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
        check("sel",       {31'b0, bus.sel},       {31'b0, m_sel});
        @(posedge clk);
        if (gx) begin
            m_out = bus.x; m_sel = 1'b1; m_valid = 1'b1; m_lastx = 1'b1;
        end else if (gy) begin
            m_out = bus.y; m_sel = 1'b0; m_valid = 1'b1; m_lastx = 1'b0;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_w;

        rst = 1'b1;
        bus.x = '0; bus.y = '0;
        bus.x_valid = 1'b0; bus.y_valid = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // reset state; requests during reset must not be accepted
        check("rst_out",   {22'b0, bus.out}, 32'h0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_sel",   {31'b0, bus.sel}, 32'h0);
        bus.x_valid = 1'b1; bus.y_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        tick();

        // single x word after release, latency 1
        rst = 1'b1;
        bus.y_valid = 1'b0;
        bus.x = 10'h155;
        tick();
        check("first_out",   {22'b0, bus.out}, 32'h155);
        check("first_sel",   {31'b0, bus.sel}, 32'h1);
        check("first_valid", {31'b0, bus.out_valid}, 32'h1);

        // fresh reset, then continuous contention x=1, y=2
        rst = 1'b0; model_reset();
        bus.x_valid = 1'b0;
        tick();
        rst = 1'b1;
        bus.x = 10'd1; bus.y = 10'd2;
        bus.x_valid = 1'b1; bus.y_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef ARB_MUX_RR_EN
            exp_w = (k % 2 == 0) ? 10'd1 : 10'd2;
`else
            exp_w = 10'd1;
`endif
            check("contend_out", {22'b0, bus.out}, {22'b0, exp_w});
            check("contend_sel", {31'b0, bus.sel}, {31'b0, (exp_w == 10'd1)});
        end

        // hold under back-pressure
        bus.y_valid = 1'b0;
        bus.x = 10'h3FF;
        tick();
        check("load_3ff", {22'b0, bus.out}, 32'h3FF);
        bus.x = 10'h0AB;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_out",   {22'b0, bus.out}, 32'h3FF);
            check("hold_valid", {31'b0, bus.out_valid}, 32'h1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_out", {22'b0, bus.out}, 32'h0AB);
        check("release_sel", {31'b0, bus.sel}, 32'h1);

        // asynchronous reset while FULL, mid-cycle
        bus.x_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b0; model_reset();
        #1;
        check("async_out",   {22'b0, bus.out}, 32'h0);
        check("async_valid", {31'b0, bus.out_valid}, 32'h0);
        @(posedge clk); #1;
        bus.x = 10'h011; bus.y = 10'h022;
        bus.x_valid = 1'b1; bus.y_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_out", {22'b0, bus.out}, 32'h011);
        check("post_rst_sel", {31'b0, bus.sel}, 32'h1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0; model_reset();
            end else begin
                rst = 1'b1;
            end
            bus.x = W'($urandom);
            bus.y = W'($urandom);
            bus.x_valid = ($urandom_range(0, 3) != 0);
            bus.y_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
